// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage: drives the PC register input,
// issues one memory request at a time and hands each word to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_FAULT
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic        r_fault;
    logic [31:0] r_fetch_count;

    logic        w_aligned;
    logic        w_capture;
    logic        w_deliver;
    logic        w_clear_valid;
    logic        w_set_fault;

    assign w_aligned     = (pc_in[1:0] == 2'b00);
    assign imem_req_addr = pc_in;
    assign id_valid      = r_id_valid;
    assign id_instr      = r_id_instr;
    assign id_pc         = r_id_pc;
    assign fault         = r_fault;
    assign fetch_count   = r_fetch_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        imem_req_valid = 1'b0;
        pc_next        = pc_in;
        w_capture      = 1'b0;
        w_deliver      = 1'b0;
        w_clear_valid  = 1'b0;
        w_set_fault    = 1'b0;
        case (r_state)
            S_REQ: begin
                imem_req_valid = w_aligned && !redirect_valid;
                if (redirect_valid) pc_next = redirect_target;
                if (!w_aligned) begin
                    w_state_next = S_FAULT;
                    w_set_fault  = 1'b1;
                end else if (imem_req_valid && imem_req_ready) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_next      = redirect_target;
                    w_state_next = imem_resp_valid ? S_REQ : S_DRAIN;
                end else if (imem_resp_valid) begin
                    pc_next      = pc_in + 32'd4;
                    w_capture    = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_next       = redirect_target;
                    w_clear_valid = 1'b1;
                    w_state_next  = S_REQ;
                end else if (id_ready) begin
                    w_deliver     = 1'b1;
                    w_clear_valid = 1'b1;
                    w_state_next  = S_REQ;
                end
            end
            S_DRAIN: begin
                // The in-flight response belongs to the abandoned path; only the PC follows redirects here.
                if (redirect_valid) pc_next = redirect_target;
                if (imem_resp_valid) w_state_next = S_REQ;
            end
            S_FAULT: begin
            end
            default: w_state_next = S_REQ;
        endcase
        if (reset) begin
            pc_next        = RESET_PC;
            imem_req_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_id_valid    <= 1'b0;
            r_id_instr    <= '0;
            r_id_pc       <= '0;
            r_fault       <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            if (w_capture) begin
                r_id_valid <= 1'b1;
                r_id_instr <= imem_resp_data;
                r_id_pc    <= pc_in;
            end else if (w_clear_valid) begin
                r_id_valid <= 1'b0;
            end
            if (w_deliver)   r_fetch_count <= r_fetch_count + 32'd1;
            if (w_set_fault) r_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the bench owns the PC register (loads pc_next every edge).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        fault;
    logic [31:0] fetch_count;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    always #5 clk = ~clk;

    always @(posedge clk) pc_in <= pc_next;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .pc_next         (pc_next),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .fault           (fault),
        .fetch_count     (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        reset           = 1'b1;
        pc_in           = '0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        id_ready        = 1'b0;

        // Reset behaviour
        settle();
        check("rst_pc_next", pc_next, 32'h0);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        tick();
        tick();
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        settle();
        check("rst_id_valid", {31'b0, id_valid}, 32'h0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        check("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("first_req_addr", imem_req_addr, 32'h0);
        check("first_pc_next", pc_next, 32'h0);

        // Basic fetch of word at 0
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0013;
        settle();
        check("wait_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("resp_pc_next", pc_next, 32'h4);
        check("wait_id_valid", {31'b0, id_valid}, 32'h0);
        tick();
        imem_resp_valid = 1'b0;
        id_ready        = 1'b1;
        settle();
        check("hold_id_valid", {31'b0, id_valid}, 32'h1);
        check("hold_id_instr", id_instr, 32'h0000_0013);
        check("hold_id_pc", id_pc, 32'h0);
        check("hold_pc_next", pc_next, 32'h4);
        tick();
        id_ready       = 1'b0;
        imem_req_ready = 1'b1;
        settle();
        check("deliv_count", fetch_count, 32'h1);
        check("deliv_id_valid", {31'b0, id_valid}, 32'h0);
        check("req2_addr", imem_req_addr, 32'h4);
        check("req2_valid", {31'b0, imem_req_valid}, 32'h1);

        // Decode stall in HOLD
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hAAAA_0001;
        settle();
        check("resp2_pc_next", pc_next, 32'h8);
        tick();
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("stall_id_valid", {31'b0, id_valid}, 32'h1);
            check("stall_id_instr", id_instr, 32'hAAAA_0001);
            check("stall_id_pc", id_pc, 32'h4);
            check("stall_pc_next", pc_next, 32'h8);
            check("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
            check("stall_count", fetch_count, 32'h1);
            tick();
        end
        id_ready = 1'b1;
        settle();
        check("stall_release_valid", {31'b0, id_valid}, 32'h1);
        tick();
        id_ready = 1'b0;
        settle();
        check("deliv2_count", fetch_count, 32'h2);
        check("req3_valid", {31'b0, imem_req_valid}, 32'h1);
        check("req3_addr", imem_req_addr, 32'h8);

        // Redirect in WAIT without response -> DRAIN
        tick();
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        settle();
        check("wait_redir_pc_next", pc_next, 32'h100);
        tick();
        redirect_valid = 1'b0;
        settle();
        check("drain_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("drain_id_valid", {31'b0, id_valid}, 32'h0);
        tick();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        settle();
        check("drain_resp_pc_next", pc_next, 32'h100);
        check("drain_resp_id_valid", {31'b0, id_valid}, 32'h0);
        tick();
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b1;
        settle();
        check("post_drain_id_valid", {31'b0, id_valid}, 32'h0);
        check("post_drain_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("post_drain_addr", imem_req_addr, 32'h100);

        // Redirect in HOLD with id_ready=1
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0055;
        tick();
        imem_resp_valid = 1'b0;
        id_ready        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        settle();
        check("hold_redir_id_instr", id_instr, 32'h0000_0055);
        check("hold_redir_pc_next", pc_next, 32'h40);
        tick();
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        imem_req_ready = 1'b1;
        settle();
        check("hold_redir_id_valid", {31'b0, id_valid}, 32'h0);
        check("hold_redir_count", fetch_count, 32'h2);
        check("hold_redir_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("hold_redir_addr", imem_req_addr, 32'h40);

        // Redirect with simultaneous response, then PC wrap and count wrap
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_1234;
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        settle();
        check("wait_redir_resp_pc_next", pc_next, 32'hFFFF_FFFC);
        tick();
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b1;
        settle();
        check("dropped_id_valid", {31'b0, id_valid}, 32'h0);
        check("top_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("top_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        force dut.r_fetch_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_fetch_count;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0077;
        settle();
        check("wrap_pc_next", pc_next, 32'h0);
        tick();
        imem_resp_valid = 1'b0;
        id_ready        = 1'b1;
        settle();
        check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_id_instr", id_instr, 32'h0000_0077);
        check("preset_count", fetch_count, 32'hFFFF_FFFF);
        tick();
        id_ready = 1'b0;
        settle();
        check("wrap_count", fetch_count, 32'h0);

        // Redirect in REQ without acceptance
        imem_req_ready  = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        settle();
        check("req_redir_valid", {31'b0, imem_req_valid}, 32'h0);
        check("req_redir_pc_next", pc_next, 32'h200);
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        settle();
        check("req_retry_valid", {31'b0, imem_req_valid}, 32'h1);
        check("req_retry_addr", imem_req_addr, 32'h200);
        tick();

        // Misaligned redirect -> sticky fault, cleared by reset
        imem_req_ready  = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h102;
        settle();
        check("mis_redir_req_valid", {31'b0, imem_req_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        settle();
        check("mis_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("mis_fault_early", {31'b0, fault}, 32'h0);
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        settle();
        check("fault_set", {31'b0, fault}, 32'h1);
        check("fault_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("fault_pc_next", pc_next, 32'h102);
        check("fault_id_valid", {31'b0, id_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        settle();
        check("fault_sticky", {31'b0, fault}, 32'h1);
        check("fault_pc_hold", pc_in, 32'h102);
        tick();
        reset           = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_BAD0;
        settle();
        check("rst2_pc_next", pc_next, 32'h0);
        check("rst2_req_valid", {31'b0, imem_req_valid}, 32'h0);
        tick();
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        settle();
        check("rst2_fault", {31'b0, fault}, 32'h0);
        check("rst2_count", fetch_count, 32'h0);
        check("rst2_req_valid_after", {31'b0, imem_req_valid}, 32'h1);
        check("rst2_addr", imem_req_addr, 32'h0);
        tick();
        imem_resp_valid = 1'b0;
        settle();
        check("stale_resp_id_valid", {31'b0, id_valid}, 32'h0);
        check("stale_resp_req_valid", {31'b0, imem_req_valid}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
